dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port: accepts load/store requests from the pipeline's MEM stage, performs byte/half/word accesses on an internal word-organised SRAM, and returns sign- or zero-extended load data.
- Owns all `DMType` decoding, byte-lane steering and extension, so the core issues raw address/data.
- Optionally splits word-crossing misaligned accesses into two array beats through a small FSM.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_sram.sv | 27 ++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared DMType encodings, FSM state type and access-size helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Access size in bytes; 0 marks an illegal encoding.
    function automatic logic [2:0] dm_size(input logic [2:0] dmtype);
        case (dmtype)
            DM_WORD:            dm_size = 3'd4;
            DM_HALF, DM_HALFU:  dm_size = 3'd2;
            DM_BYTE, DM_BYTEU:  dm_size = 3'd1;
            default:            dm_size = 3'd0;
        endcase
    endfunction

    function automatic logic dm_signed(input logic [2:0] dmtype);
        dm_signed = (dmtype == DM_HALF) || (dmtype == DM_BYTE);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size);
        case (size)
            3'd4:    lane_mask = 4'b1111;
            3'd2:    lane_mask = 4'b0011;
            3'd1:    lane_mask = 4'b0001;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised data array: synchronous read-first port with per-byte write enables.
module dmem_sram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter              INIT_FILE   = "",
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Old contents are read before the byte-enabled write lands.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: decodes DMType, steers byte lanes, extends load data.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two array beats.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dmtype,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t        state;
    logic          accept;
    logic [2:0]    acc_size;
    logic [3:0]    acc_end;
    logic          acc_cross;
    logic          acc_err;

    logic          we_q;
    logic          sgn_q;
    logic          err_q;
    logic [1:0]    off_q;
    logic [2:0]    size_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [4:0]    sh;

    logic          sram_en;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic [31:0]   rword;
    logic [31:0]   ld_data;

    assign accept = req_valid && req_ready;

    // Classify the incoming request while it is still on the port.
    always_comb begin
        acc_size  = dm_size(req_dmtype);
        acc_end   = {2'b00, req_addr[1:0]} + {1'b0, acc_size};
        acc_cross = acc_end > 4'd4;
        acc_err   = (acc_size == 3'd0)
                 || ({2'b00, req_addr[31:2]} >= DEPTH_WORDS)
                 || (acc_cross && (({1'b0, req_addr[31:2]} + 31'd1) >= 31'(DEPTH_WORDS)));
`ifndef DMEM_MISALIGN_SPLIT_EN
        acc_err   = acc_err || acc_cross;
`endif
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            we_q    <= req_we;
            sgn_q   <= dm_signed(req_dmtype);
            err_q   <= acc_err;
            off_q   <= req_addr[1:0];
            size_q  <= acc_size;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
        end
    end

    assign sh = {off_q, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic        cross_q;
    logic [31:0] lo_q;
    logic [63:0] wsh;
    logic [7:0]  msk;

    always_ff @(posedge clk) begin
        if (state == IDLE && accept) cross_q <= acc_cross;
        if (state == BEAT2)          lo_q    <= sram_rdata;
    end

    // Lanes past byte 3 spill into the next word on beat 2.
    always_comb begin
        wsh        = 64'(wdata_q) << sh;
        msk        = 8'(lane_mask(size_q)) << off_q;
        sram_en    = !err_q && (state == BEAT1 || state == BEAT2);
        sram_addr  = (state == BEAT2) ? idx_q + AW'(1) : idx_q;
        sram_wdata = (state == BEAT2) ? wsh[63:32] : wsh[31:0];
        sram_be    = !we_q ? 4'b0000 : ((state == BEAT2) ? msk[7:4] : msk[3:0]);
        rword      = cross_q ? 32'({sram_rdata, lo_q} >> sh) : 32'({32'h0, sram_rdata} >> sh);
    end
`else
    always_comb begin
        sram_en    = !err_q && (state == BEAT1);
        sram_addr  = idx_q;
        sram_wdata = wdata_q << sh;
        sram_be    = we_q ? (lane_mask(size_q) << off_q) : 4'b0000;
        rword      = sram_rdata >> sh;
    end
`endif

    always_comb begin
        ld_data = rword;
        case (size_q)
            3'd1:    ld_data = sgn_q ? {{24{rword[7]}}, rword[7:0]} : {24'h0, rword[7:0]};
            3'd2:    ld_data = sgn_q ? {{16{rword[15]}}, rword[15:0]} : {16'h0, rword[15:0]};
            default: ld_data = rword;
        endcase
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .addr  (sram_addr),
        .be    (sram_be),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    // req_ready stays low through the response pulse so the next accept lands a cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BEAT1;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BEAT1: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                    state <= (cross_q && !err_q) ? BEAT2 : RESP;
`else
                    state <= RESP;
`endif
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                BEAT2: state <= RESP;
`endif
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= (err_q || we_q) ? 32'h0 : ld_data;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; expectations follow DMEM_MISALIGN_SPLIT_EN when defined.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dmtype;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   rsp_count = 0;
    logic ready_next = 1'b0;

    dmem_responder #(.DEPTH_WORDS(1024), .INIT_FILE("")) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_dmtype (req_dmtype),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever a response pulse is seen.
    always @(negedge clk) begin
        exp_t e;
        if (ready_next && !reset) chk("ready_after_rsp", 32'(req_ready), 32'd1);
        ready_next = 1'b0;
        if (rsp_valid) begin
            rsp_count++;
            ready_next = 1'b1;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got err=%0b rdata=0x%08h expected no response", rsp_err, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
                chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
                chk({e.name, "_ready_low"}, 32'(req_ready), 32'd0);
            end
        end
    end

    task automatic wait_ready(input string name, output logic ok);
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(negedge clk); #1;
        end
        ok = req_ready;
        if (!ok) begin
            total++;
            $display("FAIL %s_timeout: got req_ready=0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] dmt, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_dmtype = dmt;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_dmtype = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic issue(input string name, input logic we, input logic [2:0] dmt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata, input int lat);
        exp_t e;
        logic ok;
        wait_ready(name, ok);
        if (!ok) return;
        e.name = name; e.err = err; e.rdata = rdata; e.lat = lat; e.acc = cyc + 1;
        exp_q.push_back(e);
        drive(we, dmt, addr, wdata);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL %s_rsp_timeout: got no response expected one within 10 cycles", name);
            exp_q.delete();
        end
    endtask

    initial begin
        logic ok;
        int   cnt;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_dmtype = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk("rel_ready", 32'(req_ready), 32'd1);

        // Known background contents
        issue("st_20", 1, 3'b000, 32'h20, 32'hAABBCCDD, 0, 32'h0, 2);
        issue("st_2c", 1, 3'b000, 32'h2C, 32'h01020304, 0, 32'h0, 2);
        issue("st_30", 1, 3'b000, 32'h30, 32'h05060708, 0, 32'h0, 2);
        issue("st_ffc", 1, 3'b000, 32'hFFC, 32'h0BADF00D, 0, 32'h0, 2);
        issue("st_10", 1, 3'b000, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2);
        issue("ld_10", 0, 3'b000, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2);

        // Byte/half lanes and extension
        issue("stb_21", 1, 3'b011, 32'h21, 32'h12345680, 0, 32'h0, 2);
        issue("lb_21", 0, 3'b011, 32'h21, 32'h0, 0, 32'hFFFFFF80, 2);
        issue("lbu_21", 0, 3'b100, 32'h21, 32'h0, 0, 32'h00000080, 2);
        issue("lw_20", 0, 3'b000, 32'h20, 32'h0, 0, 32'hAABB80DD, 2);
        issue("lh_22", 0, 3'b001, 32'h22, 32'h0, 0, 32'hFFFFAABB, 2);
        issue("lhu_22", 0, 3'b010, 32'h22, 32'h0, 0, 32'h0000AABB, 2);
        issue("lh_21", 0, 3'b001, 32'h21, 32'h0, 0, 32'hFFFFBB80, 2);
        issue("sth_12", 1, 3'b001, 32'h12, 32'hFFFF1234, 0, 32'h0, 2);
        issue("stbu_13", 1, 3'b100, 32'h13, 32'hFFFFFF7F, 0, 32'h0, 2);
        issue("lw_10b", 0, 3'b000, 32'h10, 32'h0, 0, 32'h7F34BEEF, 2);
        issue("lb_13", 0, 3'b011, 32'h13, 32'h0, 0, 32'h0000007F, 2);

        // Word-crossing accesses
`ifdef DMEM_MISALIGN_SPLIT_EN
        issue("st_split", 1, 3'b000, 32'h2E, 32'h11223344, 0, 32'h0, 3);
        issue("lw_2c", 0, 3'b000, 32'h2C, 32'h0, 0, 32'h33440304, 2);
        issue("lw_30", 0, 3'b000, 32'h30, 32'h0, 0, 32'h05061122, 2);
        issue("lw_split", 0, 3'b000, 32'h2E, 32'h0, 0, 32'h11223344, 3);
        issue("lhu_split", 0, 3'b010, 32'h2F, 32'h0, 0, 32'h00002233, 3);
`else
        issue("st_split", 1, 3'b000, 32'h2E, 32'h11223344, 1, 32'h0, 2);
        issue("lw_2c", 0, 3'b000, 32'h2C, 32'h0, 0, 32'h01020304, 2);
        issue("lw_30", 0, 3'b000, 32'h30, 32'h0, 0, 32'h05060708, 2);
        issue("lw_split", 0, 3'b000, 32'h2E, 32'h0, 1, 32'h0, 2);
        issue("lhu_split", 0, 3'b010, 32'h2F, 32'h0, 1, 32'h0, 2);
`endif

        // Range and illegal encodings
        issue("ld_oor", 0, 3'b000, 32'h1000, 32'h0, 1, 32'h0, 2);
        issue("st_split_oor", 1, 3'b000, 32'hFFE, 32'hFFFFFFFF, 1, 32'h0, 2);
        issue("lw_ffc", 0, 3'b000, 32'hFFC, 32'h0, 0, 32'h0BADF00D, 2);
        issue("ld_dm101", 0, 3'b101, 32'h10, 32'h0, 1, 32'h0, 2);
        issue("st_dm111", 1, 3'b111, 32'h10, 32'h0, 1, 32'h0, 2);
        issue("lw_10c", 0, 3'b000, 32'h10, 32'h0, 0, 32'h7F34BEEF, 2);

        // Reset arriving one cycle after the first beat of a crossing store
        wait_ready("rst_split", ok);
        if (ok) begin
            cnt = rsp_count;
            drive(1, 3'b000, 32'h2E, 32'hCAFEBABE);
            @(posedge clk); @(negedge clk);
            reset = 1'b1;
            #1;
            chk("mid_rst_ready", 32'(req_ready), 32'd0);
            chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            @(posedge clk); @(negedge clk); #1;
            chk("post_rst_ready", 32'(req_ready), 32'd1);
            chk("post_rst_no_rsp", 32'(rsp_count - cnt), 32'd0);
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        issue("lw_2c_rst", 0, 3'b000, 32'h2C, 32'h0, 0, 32'hBABE0304, 2);
        issue("lw_30_rst", 0, 3'b000, 32'h30, 32'h0, 0, 32'h05061122, 2);
`else
        issue("lw_2c_rst", 0, 3'b000, 32'h2C, 32'h0, 0, 32'h01020304, 2);
        issue("lw_30_rst", 0, 3'b000, 32'h30, 32'h0, 0, 32'h05060708, 2);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
